// File: rtl/riscv_cache_refill.sv
// riscv_cache_refill: critical-word-first line refill engine for the cache miss path.
// Issues one wrapping read burst to the BIU, forwards the first returned beat to
// the core and writes the assembled line back in a single cycle.

package riscv_cache_refill_pkg;

  typedef logic [2:0] biu_prot_t;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HWORD = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3,
    QWORD = 3'd4
  } biu_size_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } biu_type_t;

endpackage

module riscv_cache_refill
  import riscv_cache_refill_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PLEN       = XLEN,
  parameter int BLOCK_SIZE = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  miss_req_i,
  input  logic [PLEN-1:0]       miss_adr_i,
  input  biu_prot_t             miss_prot_i,
  input  logic                  flush_i,
  output logic                  busy_o,

  output logic                  biu_stb_o,
  input  logic                  biu_stb_ack_i,
  output logic [PLEN-1:0]       biu_adri_o,
  output biu_size_t             biu_size_o,
  output biu_type_t             biu_type_o,
  output biu_prot_t             biu_prot_o,
  output logic                  biu_we_o,
  output logic                  biu_lock_o,
  input  logic [XLEN-1:0]       biu_d_i,
  input  logic                  biu_ack_i,
  input  logic                  biu_err_i,

  output logic [XLEN-1:0]       q_o,
  output logic                  q_valid_o,

  output logic                  line_we_o,
  output logic [PLEN-1:0]       line_adr_o,
  output logic [BLOCK_SIZE-1:0] line_o,
  output logic                  err_o
);

  localparam int BURST_LEN     = BLOCK_SIZE / XLEN;
  localparam int BLK_OFFS_BITS = $clog2(BLOCK_SIZE / 8);
  localparam int WORD_BITS     = $clog2(BURST_LEN);

  localparam logic [PLEN-1:0] WORD_MASK = ~PLEN'(XLEN / 8 - 1);
  localparam logic [PLEN-1:0] LINE_MASK = ~PLEN'(BLOCK_SIZE / 8 - 1);

  localparam biu_size_t BURST_SIZE = (XLEN == 64) ? DWORD : WORD;
  localparam biu_type_t BURST_TYPE = (BURST_LEN == 4) ? WRAP4 :
                                     (BURST_LEN == 8) ? WRAP8 : WRAP16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA,
    WRITE
  } state_t;

  state_t                state_q, state_d;

  logic [PLEN-1:0]       adr_q;
  biu_prot_t             prot_q;
  logic [WORD_BITS-1:0]  start_q;
  logic [WORD_BITS-1:0]  cnt_q;
  logic [WORD_BITS-1:0]  slot;
  logic                  drop_q;
  logic [XLEN-1:0]       q_q;
  logic                  q_valid_q;
  logic                  err_q;
  logic [XLEN-1:0]       line_q [BURST_LEN];

  logic                  accept;
  logic                  err_d;

  assign slot = start_q + cnt_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode, beat acceptance and state-derived outputs
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    err_d      = 1'b0;
    busy_o     = (state_q != IDLE);
    biu_stb_o  = (state_q == REQ);
    line_we_o  = (state_q == WRITE);
    biu_adri_o = adr_q;
    biu_prot_o = prot_q;
    biu_size_o = BURST_SIZE;
    biu_type_o = BURST_TYPE;
    biu_we_o   = 1'b0;
    biu_lock_o = 1'b0;
    q_o        = q_q;
    q_valid_o  = q_valid_q;
    err_o      = err_q;
    line_adr_o = adr_q & LINE_MASK;

    unique case (state_q)
      IDLE: begin
        if (miss_req_i) state_d = REQ;
      end
      REQ: begin
        if (biu_err_i) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (biu_stb_ack_i) begin
          // A beat may already arrive together with the strobe acknowledge.
          accept  = biu_ack_i;
          state_d = DATA;
        end
      end
      DATA: begin
        if (biu_err_i) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (biu_ack_i) begin
          accept = 1'b1;
          if (cnt_q == WORD_BITS'(BURST_LEN - 1)) state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture, beat assembly and critical-word forwarding
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_q     <= '0;
      prot_q    <= '0;
      start_q   <= '0;
      cnt_q     <= '0;
      drop_q    <= 1'b0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < BURST_LEN; i++) line_q[i] <= '0;
    end else begin
      q_valid_q <= 1'b0;
      err_q     <= err_d;

      if (state_q == IDLE) begin
        if (miss_req_i) begin
          adr_q   <= miss_adr_i & WORD_MASK;
          prot_q  <= miss_prot_i;
          start_q <= miss_adr_i[BLK_OFFS_BITS-1 -: WORD_BITS];
          cnt_q   <= '0;
          drop_q  <= 1'b0;
        end
      end else if (flush_i) begin
        drop_q <= 1'b1;
      end

      if (accept) begin
        line_q[slot] <= biu_d_i;
        cnt_q        <= cnt_q + 1'b1;
        // Same-cycle flush must already suppress the critical word.
        if (cnt_q == '0 && !drop_q && !flush_i) begin
          q_q       <= biu_d_i;
          q_valid_q <= 1'b1;
        end
      end
    end
  end

  // Flatten the word array into the line bus
  always_comb begin
    line_o = '0;
    for (int unsigned i = 0; i < BURST_LEN; i++) line_o[i*XLEN +: XLEN] = line_q[i];
  end

endmodule
